// File: rtl/modulo_gerenciador_rolhas_param_pkg.sv
// rtl/modulo_gerenciador_rolhas_param_pkg.sv - shared state encoding and parameter defaults
//
// Purpose: constants shared by the cork buffer manager and its bench.
//   ST_IDLE / ST_LOAD / ST_TRANSFER : 2-bit FSM state encodings (11 unused)
//   *_DEF                            : default values of the top-level parameters
package modulo_gerenciador_rolhas_param_pkg;

   localparam logic [1:0] ST_IDLE     = 2'b00;
   localparam logic [1:0] ST_LOAD     = 2'b01;
   localparam logic [1:0] ST_TRANSFER = 2'b10;

   localparam int W_DEF       = 7;
   localparam int CAP_PRI_DEF = 20;
   localparam int CAP_SEC_DEF = 99;
   localparam int MIN_PRI_DEF = 5;
   localparam int LOTE_DEF    = 15;

endpackage

// File: rtl/modulo_contador_sat_param.sv
// rtl/modulo_contador_sat_param.sv - W-bit up/down counter with load, saturating at 0 and MAX
//
// Purpose: buffer level counter.
//   clk      in  1  clock, rising edge
//   clr      in  1  asynchronous active-low reset (count -> 0)
//   load     in  1  load load_val (has priority over inc/dec)
//   load_val in  W  value to load
//   inc      in  1  count up by one, held at MAX
//   dec      in  1  count down by one, held at 0
//   count    out W  current level
// inc and dec together cancel out and leave the count unchanged.
module modulo_contador_sat_param #(
   parameter int W   = 7,
   parameter int MAX = 99
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (inc && !dec && count != MAX_V) begin
         count <= count + 1'b1;
      end else if (dec && !inc && count != '0) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/modulo_gerenciador_rolhas_param.sv
// rtl/modulo_gerenciador_rolhas_param.sv - cork buffer manager (principal/secondary buffers)
//
// Purpose: keeps the sealer's principal cork buffer topped up from a secondary
// buffer that the operator refills.
//   clk      in  1  clock, rising edge
//   clr      in  1  asynchronous active-low reset
//   enable   in  1  run/hold of the FSM (consumption always applies)
//   consome  in  1  pulse: one cork used from the principal buffer
//   op_load  in  1  pulse: operator adds op_qty corks to the secondary buffer
//   op_qty   in  W  quantity for op_load
//   buf_pri  out W  principal buffer level
//   buf_sec  out W  secondary buffer level
//   ro       out 1  principal buffer empty
//   transf   out 1  transfer in progress
//   load_rej out 1  pulse: load rejected for overflow
//   estado   out 2  FSM state
module modulo_gerenciador_rolhas_param
   import modulo_gerenciador_rolhas_param_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int CAP_PRI = CAP_PRI_DEF,
   parameter int CAP_SEC = CAP_SEC_DEF,
   parameter int MIN_PRI = MIN_PRI_DEF,
   parameter int LOTE    = LOTE_DEF
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         enable,
   input  logic         consome,
   input  logic         op_load,
   input  logic [W-1:0] op_qty,
   output logic [W-1:0] buf_pri,
   output logic [W-1:0] buf_sec,
   output logic         ro,
   output logic         transf,
   output logic         load_rej,
   output logic [1:0]   estado
);

   if (CAP_SEC >= (1 << W) || CAP_PRI > CAP_SEC || MIN_PRI >= CAP_PRI
       || LOTE < 1 || LOTE > CAP_PRI) begin : g_bad_params
      $error("modulo_gerenciador_rolhas_param: illegal parameter combination");
   end

   localparam logic [W-1:0] CAP_PRI_V  = W'(CAP_PRI);
   localparam logic [W-1:0] CAP_PRI_M1 = W'(CAP_PRI - 1);
   localparam logic [W-1:0] MIN_PRI_V  = W'(MIN_PRI);
   localparam logic [W-1:0] LOTE_M1    = W'(LOTE - 1);
   localparam logic [W:0]   CAP_SEC_V  = (W+1)'(CAP_SEC);

   logic [1:0]   state;
   logic [1:0]   state_next;
   logic         pending;
   logic [W-1:0] qty;
   logic [W-1:0] move_cnt;
   logic [W:0]   load_sum;
   logic         load_fits;
   logic         can_move;
   logic         move;
   logic         last_move;

   // Extra bit so an overflowing load is detected rather than wrapped.
   assign load_sum  = {1'b0, buf_sec} + {1'b0, qty};
   assign load_fits = (load_sum <= CAP_SEC_V);

   assign can_move = (buf_sec != '0) && (buf_pri != CAP_PRI_V);
   assign move     = (state == ST_TRANSFER) && enable && can_move;

   // A move with a simultaneous consume leaves buf_pri where it was, so it
   // cannot be the move that fills the principal buffer.
   assign last_move = move && ((move_cnt == LOTE_M1) || (buf_sec == W'(1))
                               || (buf_pri == CAP_PRI_M1 && !consome));

   always_comb begin
      state_next = ST_IDLE;
      case (state)
         ST_IDLE: begin
            if (enable && pending)
               state_next = ST_LOAD;
            else if (enable && buf_pri <= MIN_PRI_V && buf_sec != '0)
               state_next = ST_TRANSFER;
            else
               state_next = ST_IDLE;
         end
         ST_LOAD:     state_next = ST_IDLE;
         ST_TRANSFER: state_next = (move && !last_move) ? ST_TRANSFER : ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= ST_IDLE;
         pending  <= 1'b0;
         qty      <= '0;
         move_cnt <= '0;
         load_rej <= 1'b0;
      end else begin
         state    <= state_next;
         load_rej <= (state == ST_LOAD) && !load_fits;

         // A new request in the LOAD cycle itself stays pending.
         if (op_load) begin
            pending <= 1'b1;
            qty     <= op_qty;
         end else if (state == ST_LOAD) begin
            pending <= 1'b0;
         end

         // Staying in TRANSFER implies a move happened this cycle.
         if (state == ST_TRANSFER && state_next == ST_TRANSFER)
            move_cnt <= move_cnt + 1'b1;
         else
            move_cnt <= '0;
      end
   end

   modulo_contador_sat_param #(.W(W), .MAX(CAP_PRI)) u_cnt_pri (
      .clk      (clk),
      .clr      (clr),
      .load     (1'b0),
      .load_val ('0),
      .inc      (move),
      .dec      (consome),
      .count    (buf_pri)
   );

   modulo_contador_sat_param #(.W(W), .MAX(CAP_SEC)) u_cnt_sec (
      .clk      (clk),
      .clr      (clr),
      .load     ((state == ST_LOAD) && load_fits),
      .load_val (load_sum[W-1:0]),
      .inc      (1'b0),
      .dec      (move),
      .count    (buf_sec)
   );

   assign ro     = (buf_pri == '0);
   assign transf = (state == ST_TRANSFER);
   assign estado = state;

endmodule

// File: tb/tb_modulo_gerenciador_rolhas_param.sv
// tb/tb_modulo_gerenciador_rolhas_param.sv - directed bench for the cork buffer manager
module tb_modulo_gerenciador_rolhas_param;

   logic       clk = 1'b0;
   logic       clr;
   logic       enable;
   logic       consome;
   logic       op_load;
   logic [6:0] op_qty;
   logic [6:0] buf_pri;
   logic [6:0] buf_sec;
   logic       ro;
   logic       transf;
   logic       load_rej;
   logic [1:0] estado;

   int checks   = 0;
   int failures = 0;

   modulo_gerenciador_rolhas_param dut (
      .clk      (clk),
      .clr      (clr),
      .enable   (enable),
      .consome  (consome),
      .op_load  (op_load),
      .op_qty   (op_qty),
      .buf_pri  (buf_pri),
      .buf_sec  (buf_sec),
      .ro       (ro),
      .transf   (transf),
      .load_rej (load_rej),
      .estado   (estado)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      clr     = 1'b0;
      enable  = 1'b0;
      consome = 1'b0;
      op_load = 1'b0;
      op_qty  = '0;
      tick();
      tick();
      clr = 1'b1;
   endtask

   task automatic pulse_load(input logic [6:0] q);
      op_load = 1'b1;
      op_qty  = q;
      tick();
      op_load = 1'b0;
   endtask

   // Clocks until a transfer has been seen and ended; n = cycles spent in TRANSFER.
   task automatic run_transfer(output int n);
      bit done = 0;
      n = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         tick();
         if (estado == 2'b10) n++;
         else if (n > 0) done = 1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL transfer_timeout got=%0d transfer cycles, required end of transfer", n);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      clr = 1'b0;
      #1;
      checks++;
      if ({estado, buf_pri, buf_sec, ro, transf, load_rej} !== {2'b00, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_outputs got est=%0d pri=%0d sec=%0d ro=%0d tr=%0d rej=%0d required 0 0 0 1 0 0",
                  estado, buf_pri, buf_sec, ro, transf, load_rej);
      end
      clr = 1'b1;
   endtask

   task automatic test_load_transfer();
      int n;
      apply_reset();
      enable = 1'b1;
      pulse_load(7'd30);
      tick();
      checks++;
      if (estado !== 2'b01) begin failures++; $display("FAIL load_state got=%0d required=1", estado); end
      tick();
      checks++;
      if (estado !== 2'b00 || buf_sec !== 7'd30) begin
         failures++; $display("FAIL load_done got est=%0d sec=%0d required 0 30", estado, buf_sec);
      end
      tick();
      checks++;
      if (transf !== 1'b1) begin failures++; $display("FAIL transf_flag got=%0d required=1", transf); end
      run_transfer(n);
      n++;
      checks++;
      if (n !== 15) begin failures++; $display("FAIL transfer_len got=%0d required=15", n); end
      checks++;
      if (buf_pri !== 7'd15 || buf_sec !== 7'd15 || ro !== 1'b0) begin
         failures++; $display("FAIL transfer_levels got pri=%0d sec=%0d ro=%0d required 15 15 0", buf_pri, buf_sec, ro);
      end
   endtask

   task automatic test_reject();
      // continues from pri=15, sec=15
      pulse_load(7'd75);
      tick();
      tick();
      checks++;
      if (buf_sec !== 7'd90) begin failures++; $display("FAIL reject_setup got=%0d required=90", buf_sec); end
      pulse_load(7'd10);
      tick();
      tick();
      checks++;
      if (load_rej !== 1'b1 || buf_sec !== 7'd90) begin
         failures++; $display("FAIL reject_pulse got rej=%0d sec=%0d required 1 90", load_rej, buf_sec);
      end
      tick();
      checks++;
      if (load_rej !== 1'b0) begin failures++; $display("FAIL reject_width got=%0d required=0", load_rej); end
      pulse_load(7'd9);
      tick();
      tick();
      checks++;
      if (load_rej !== 1'b0 || buf_sec !== 7'd99) begin
         failures++; $display("FAIL load_to_cap got rej=%0d sec=%0d required 0 99", load_rej, buf_sec);
      end
   endtask

   task automatic test_small_batch();
      int n;
      apply_reset();
      enable = 1'b1;
      pulse_load(7'd4);
      run_transfer(n);
      checks++;
      if (buf_pri !== 7'd4 || buf_sec !== 7'd0) begin
         failures++; $display("FAIL batch_setup got pri=%0d sec=%0d required 4 0", buf_pri, buf_sec);
      end
      consome = 1'b1;
      tick();
      consome = 1'b0;
      tick();
      checks++;
      if (buf_pri !== 7'd3 || estado !== 2'b00) begin
         failures++; $display("FAIL batch_consume got pri=%0d est=%0d required 3 0", buf_pri, estado);
      end
      pulse_load(7'd4);
      run_transfer(n);
      checks++;
      if (n !== 4) begin failures++; $display("FAIL batch_len got=%0d required=4", n); end
      checks++;
      if (buf_pri !== 7'd7 || buf_sec !== 7'd0 || estado !== 2'b00) begin
         failures++; $display("FAIL batch_levels got pri=%0d sec=%0d est=%0d required 7 0 0", buf_pri, buf_sec, estado);
      end
   endtask

   task automatic test_consume_during_transfer();
      int n;
      apply_reset();
      enable = 1'b1;
      pulse_load(7'd30);
      tick();
      tick();
      tick();
      consome = 1'b1;
      tick();
      consome = 1'b0;
      checks++;
      if (buf_pri !== 7'd0 || buf_sec !== 7'd29) begin
         failures++; $display("FAIL move_consume got pri=%0d sec=%0d required 0 29", buf_pri, buf_sec);
      end
      tick();
      tick();
      consome = 1'b1;
      tick();
      consome = 1'b0;
      run_transfer(n);
      checks++;
      if (buf_pri !== 7'd13 || buf_sec !== 7'd15) begin
         failures++; $display("FAIL consume_levels got pri=%0d sec=%0d required 13 15", buf_pri, buf_sec);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      enable = 1'b1;
      pulse_load(7'd30);
      tick();
      tick();
      tick();
      repeat (4) tick();
      checks++;
      if (estado !== 2'b10 || buf_pri !== 7'd4) begin
         failures++; $display("FAIL midxfer_state got est=%0d pri=%0d required 2 4", estado, buf_pri);
      end
      #2 clr = 1'b0;
      #1;
      checks++;
      if ({estado, buf_pri, buf_sec, ro, transf, load_rej} !== {2'b00, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL async_clear got est=%0d pri=%0d sec=%0d ro=%0d tr=%0d rej=%0d required 0 0 0 1 0 0",
                  estado, buf_pri, buf_sec, ro, transf, load_rej);
      end
      tick();
      clr = 1'b1;
      tick();
      checks++;
      if (estado !== 2'b00 || buf_pri !== 7'd0) begin
         failures++; $display("FAIL after_release got est=%0d pri=%0d required 0 0", estado, buf_pri);
      end
   endtask

   task automatic test_enable_drop();
      int n;
      apply_reset();
      enable = 1'b1;
      pulse_load(7'd30);
      tick();
      tick();
      tick();
      enable  = 1'b0;
      consome = 1'b1;
      tick();
      consome = 1'b0;
      checks++;
      if (estado !== 2'b00 || buf_pri !== 7'd0 || ro !== 1'b1 || buf_sec !== 7'd30) begin
         failures++; $display("FAIL enable_exit got est=%0d pri=%0d ro=%0d sec=%0d required 0 0 1 30",
                              estado, buf_pri, ro, buf_sec);
      end
      tick();
      checks++;
      if (estado !== 2'b00) begin failures++; $display("FAIL enable_hold got=%0d required=0", estado); end
      enable = 1'b1;
      run_transfer(n);
      checks++;
      if (n !== 15 || buf_pri !== 7'd15 || buf_sec !== 7'd15) begin
         failures++; $display("FAIL reenable got n=%0d pri=%0d sec=%0d required 15 15 15", n, buf_pri, buf_sec);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      pulse_load(7'd10);
      pulse_load(7'd25);
      tick();
      checks++;
      if (estado !== 2'b00 || buf_sec !== 7'd0) begin
         failures++; $display("FAIL disabled_hold got est=%0d sec=%0d required 0 0", estado, buf_sec);
      end
      enable = 1'b1;
      tick();
      tick();
      checks++;
      if (buf_sec !== 7'd25) begin failures++; $display("FAIL overwrite_qty got=%0d required=25", buf_sec); end
   endtask

   initial begin
      test_reset();
      test_load_transfer();
      test_reject();
      test_small_batch();
      test_consume_during_transfer();
      test_async_reset();
      test_enable_drop();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
